// File: rtl/gp_timer.sv
// gp_timer: prescaled up/down timer with N compare/PWM channels and a registered level irq.
// Define GP_TIMER_PRELOAD_EN to buffer PSC/ARR writes until the next update event.
module gp_timer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 16,
  parameter int unsigned N_CH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [CNT_W-1:0] cnt,
  output logic [N_CH-1:0]  cmp_out,
  output logic             irq
);
  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_PSC    = 4'h1;
  localparam logic [3:0] A_ARR    = 4'h2;
  localparam logic [3:0] A_CNT    = 4'h3;
  localparam logic [3:0] A_STATUS = 4'h4;

  logic             en, oneshot, dir, uie, uif;
  logic [N_CH-1:0]  ccie, ccif, ccif_set;
  logic [PSC_W-1:0] psc, psc_cnt, psc_rd;
  logic [CNT_W-1:0] arr, arr_rd, cnt_nxt;
  logic [CNT_W-1:0] ccr [N_CH];
  logic             wr_ctrl, wr_psc, wr_arr, wr_cnt, wr_status;
  logic             tick, at_limit, upd, cnt_load;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_ctrl      = wr_en && addr == A_CTRL;
  assign wr_psc       = wr_en && addr == A_PSC;
  assign wr_arr       = wr_en && addr == A_ARR;
  assign wr_cnt       = wr_en && addr == A_CNT;
  assign wr_status    = wr_en && addr == A_STATUS;
  assign unused_wdata = ^wdata;

  assign tick     = en && (psc_cnt == psc);
  assign at_limit = dir ? (cnt == '0) : (cnt == arr);
  assign upd      = tick && !wr_cnt && at_limit;
  assign cnt_load = tick || wr_cnt;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_cnt) begin
      cnt_nxt = wdata[CNT_W-1:0];
    end else if (tick) begin
      if (at_limit) cnt_nxt = dir ? arr : '0;
      else          cnt_nxt = dir ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ccif_set = '0;
    cmp_out  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ccif_set[i] = cnt_load && (cnt_nxt == ccr[i]);
      cmp_out[i]  = cnt < ccr[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      psc_cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr_cnt || tick) psc_cnt <= '0;
`ifndef GP_TIMER_PRELOAD_EN
      else if (wr_psc)    psc_cnt <= '0;
`endif
      else if (en)        psc_cnt <= psc_cnt + PSC_W'(1);
    end
  end

`ifdef GP_TIMER_PRELOAD_EN
  logic [PSC_W-1:0] psc_sh, psc_sh_nxt;
  logic [CNT_W-1:0] arr_sh, arr_sh_nxt;

  // Same-cycle shadow writes are forwarded so a disabled timer picks them up at once.
  assign psc_sh_nxt = wr_psc ? wdata[PSC_W-1:0] : psc_sh;
  assign arr_sh_nxt = wr_arr ? wdata[CNT_W-1:0] : arr_sh;
  assign psc_rd     = psc_sh;
  assign arr_rd     = arr_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_sh <= '0;
      arr_sh <= '0;
      psc    <= '0;
      arr    <= '0;
    end else begin
      psc_sh <= psc_sh_nxt;
      arr_sh <= arr_sh_nxt;
      if (upd || !en) begin
        psc <= psc_sh_nxt;
        arr <= arr_sh_nxt;
      end
    end
  end
`else
  assign psc_rd = psc;
  assign arr_rd = arr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc <= '0;
      arr <= '0;
    end else begin
      if (wr_psc) psc <= wdata[PSC_W-1:0];
      if (wr_arr) arr <= wdata[CNT_W-1:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) ccr[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (wr_en && addr[3] && addr[2:0] == 3'(i)) ccr[i] <= wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      dir     <= 1'b0;
      uie     <= 1'b0;
      ccie    <= '0;
      uif     <= 1'b0;
      ccif    <= '0;
      irq     <= 1'b0;
    end else begin
      // A software CTRL write overrides the one-shot auto-disable in the same cycle.
      if (wr_ctrl) begin
        en      <= wdata[0];
        oneshot <= wdata[1];
        dir     <= wdata[2];
        uie     <= wdata[8];
        ccie    <= wdata[9 +: N_CH];
      end else if (upd && oneshot) begin
        en <= 1'b0;
      end
      uif  <= (uif && !(wr_status && wdata[0])) || upd;
      ccif <= (ccif & ~({N_CH{wr_status}} & wdata[1 +: N_CH])) | ccif_set;
      irq  <= (uif && uie) || |(ccif & ccie);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL: begin
        rd_mux[0]         = en;
        rd_mux[1]         = oneshot;
        rd_mux[2]         = dir;
        rd_mux[8]         = uie;
        rd_mux[9 +: N_CH] = ccie;
      end
      A_PSC:    rd_mux[PSC_W-1:0] = psc_rd;
      A_ARR:    rd_mux[CNT_W-1:0] = arr_rd;
      A_CNT:    rd_mux[CNT_W-1:0] = cnt;
      A_STATUS: begin
        rd_mux[0]         = uif;
        rd_mux[1 +: N_CH] = ccif;
      end
      default: begin
        for (int unsigned i = 0; i < N_CH; i++)
          if (addr[3] && addr[2:0] == 3'(i)) rd_mux[CNT_W-1:0] = ccr[i];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_gp_timer.sv
// Directed bench for gp_timer: stimulus queues hand-computed expectations, a negedge monitor
// pops one entry per requested observation (read data or sampled output) and compares.
`timescale 1ns/1ps
module tb_gp_timer;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PSC_W = 8;
  localparam int unsigned N_CH  = 2;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_PSC    = 4'h1;
  localparam logic [3:0] A_ARR    = 4'h2;
  localparam logic [3:0] A_CNT    = 4'h3;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CCR0   = 4'h8;

  localparam int SEL_RDATA = 0;
  localparam int SEL_CNT   = 1;
  localparam int SEL_CMP   = 2;
  localparam int SEL_IRQ   = 3;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [3:0]       addr  = '0;
  logic [31:0]      wdata = '0;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  cmp_out;
  logic             irq;

  int probe_n = 0;
  int req_q   = 0;
  int checks  = 0;
  int errors  = 0;

  exp_t        mon_e;
  logic [31:0] mon_act;

  int up_seq[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
`ifdef GP_TIMER_PRELOAD_EN
  int arr_seq[10] = '{8, 9, 0, 1, 2, 3, 4, 0, 1, 2};
`else
  int arr_seq[10] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17};
`endif

  gp_timer #(.CNT_W(CNT_W), .PSC_W(PSC_W), .N_CH(N_CH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .cnt     (cnt),
    .cmp_out (cmp_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_q <= probe_n + (rd_en ? 1 : 0);

  always @(negedge clk) begin
    for (int k = 0; k < req_q; k++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: observation requested, no queued expectation");
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.sel)
          SEL_RDATA: mon_act = rdata;
          SEL_CNT:   mon_act = 32'(cnt);
          SEL_CMP:   mon_act = 32'(cmp_out);
          default:   mon_act = {31'd0, irq};
        endcase
        if (mon_act !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: actual 0x%0h required 0x%0h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic expect_sig(input int sel, input logic [31:0] exp, input string name);
    sb.push_back('{sel, exp, name});
    probe_n++;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    probe_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) end_cycle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    end_cycle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{SEL_RDATA, exp, name});
    rd_en = 1'b1;
    addr  = a;
    end_cycle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    expect_sig(SEL_CNT, 0, "rst_cnt");
    expect_sig(SEL_IRQ, 0, "rst_irq");
    expect_sig(SEL_CMP, 0, "rst_cmp");
    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_STATUS, 0, "rst_status");
    rd(A_ARR, 0, "rst_arr");

    // Basic up-count: PSC=1, ARR=3, UIE=1
    wr(A_PSC, 1);
    wr(A_ARR, 3);
    expect_sig(SEL_CNT, 0, "up_cnt_en_edge");
    wr(A_CTRL, 32'h101);
    for (int k = 0; k < 8; k++) begin
      expect_sig(SEL_CNT, up_seq[k], "up_cnt");
      if (k == 7) expect_sig(SEL_IRQ, 0, "up_irq_on_wrap_edge");
      end_cycle();
    end
    expect_sig(SEL_IRQ, 1, "up_irq_after_wrap");
    expect_sig(SEL_CNT, 0, "up_cnt_hold");
    rd(A_STATUS, 32'h7, "up_status");
    expect_sig(SEL_CNT, 1, "en_clear_on_tick_cnt");
    wr(A_CTRL, 0);
    wr(A_CNT, 0);
    wr(A_STATUS, 32'h7);
    rd(A_CTRL, 0, "ctrl_cleared");

    // One-shot down: PSC=0, ARR=5, CNT=2
    wr(A_PSC, 0);
    wr(A_ARR, 5);
    wr(A_CNT, 2);
    expect_sig(SEL_CNT, 2, "os_cnt_start");
    wr(A_CTRL, 32'h7);
    expect_sig(SEL_CNT, 1, "os_cnt_1");
    end_cycle();
    expect_sig(SEL_CNT, 0, "os_cnt_0");
    end_cycle();
    expect_sig(SEL_CNT, 5, "os_cnt_reload");
    end_cycle();
    expect_sig(SEL_CNT, 5, "os_cnt_stop");
    rd(A_CTRL, 32'h6, "os_ctrl_en_off");
    idle(100);
    expect_sig(SEL_CNT, 5, "os_cnt_after_100");
    rd(A_STATUS, 32'h7, "os_status");
    wr(A_CTRL, 0);
    wr(A_CNT, 0);
    wr(A_STATUS, 32'h7);

    // PWM: ARR=9, CCR0=3, CCR1=0, CC0IE=1
    wr(A_CCR0, 3);
    wr(A_ARR, 9);
    expect_sig(SEL_CNT, 0, "pwm_cnt_en_edge");
    wr(A_CTRL, 32'h201);
    for (int k = 1; k <= 20; k++) begin
      expect_sig(SEL_CNT, k % 10, "pwm_cnt");
      expect_sig(SEL_CMP, ((k % 10) < 3) ? 1 : 0, "pwm_cmp_out");
      if (k == 3) expect_sig(SEL_IRQ, 0, "pwm_irq_flag_edge");
      if (k == 4) begin
        expect_sig(SEL_IRQ, 1, "pwm_irq_cc0");
        rd(A_STATUS, 32'h2, "pwm_cc0if");
      end else begin
        end_cycle();
      end
    end

    // W1C of UIF on the update edge: set wins
    wr(A_STATUS, 32'h7);
    idle(8);
    expect_sig(SEL_CNT, 0, "w1c_race_cnt");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h7, "w1c_race_uif_kept");

    // CNT write on an update tick: write wins, no UIF
    wr(A_STATUS, 32'h7);
    idle(7);
    expect_sig(SEL_CNT, 7, "cntwr_race_cnt");
    wr(A_CNT, 7);
    expect_sig(SEL_CNT, 8, "cntwr_race_next");
    rd(A_STATUS, 32'h2, "cntwr_race_no_uif");

    // ARR lowered to 4 while cnt=6
    idle(8);
    expect_sig(SEL_CNT, 7, "arr_write_edge_cnt");
    wr(A_ARR, 4);
    for (int j = 0; j < 10; j++) begin
      expect_sig(SEL_CNT, arr_seq[j], "arr_change_cnt");
      if (j == 0) rd(A_ARR, 4, "arr_readback");
      else        end_cycle();
    end
`ifndef GP_TIMER_PRELOAD_EN
    idle(242);
    expect_sig(SEL_CNT, 4, "arr_wrap_reach");
    end_cycle();
    expect_sig(SEL_CNT, 0, "arr_wrap_update");
    end_cycle();
    expect_sig(SEL_CNT, 1, "arr_wrap_restart");
    end_cycle();
`endif

    // Asynchronous reset mid-count with irq high
    wr(A_CNT, 0);
    expect_sig(SEL_CNT, 1, "pre_reset_cnt");
    expect_sig(SEL_IRQ, 1, "pre_reset_irq");
    rd(A_ARR, 4, "pre_reset_rdata");
    expect_sig(SEL_CNT, 0, "async_rst_cnt");
    expect_sig(SEL_IRQ, 0, "async_rst_irq");
    expect_sig(SEL_RDATA, 0, "async_rst_rdata");
    expect_sig(SEL_CMP, 0, "async_rst_cmp_out");
    @(posedge clk);
    #1;
    reset   = 1'b1;
    probe_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_sig(SEL_CNT, 0, "post_rst_cnt");
    rd(A_CTRL, 0, "post_rst_ctrl");
    rd(A_CCR0, 0, "post_rst_ccr0");
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gp_timer.md
# gp_timer

Parametrised general-purpose timer peripheral for the RV32I microcontroller. It replaces the fixed 16-bit single-counter timer with the following features:
- configurable counter and prescaler widths;
- up or down counting;
- one-shot or periodic mode;
- N compare channels, each with a PWM output and an interrupt flag.

It sits on the core's memory-mapped register bus and drives a single level interrupt line to the core.

## Interface
- `CNT_W`, 16: counter and ARR/CCR width (2..32).
- `PSC_W`, 16: prescaler width (1..32).
- `N_CH`, 2: compare channel count (1..8).
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  register write strobe, single cycle.
- `rd_en`  in  1  register read strobe, single cycle.
- `addr`  in  4  register word address.
- `wdata`  in  32  write data; the low bits are used, upper bits are ignored.
- `rdata`  out  32  read data, registered; unused bits read 0.
- `cnt`  out  CNT_W  live counter value.
- `cmp_out`  out  N_CH  PWM outputs; bit i = (cnt < CCR[i]).
- `irq`  out  1  |(STATUS & IE), registered.

## Operation
Register map (word addresses):
- **0x0 CTRL**
  - bit0 EN, bit1 ONESHOT, bit2 DIR (0 = up, 1 = down).
  - bit8 UIE; bits[9+:N_CH] CCxIE.
- **0x1 PSC.**
- **0x2 ARR.**
- **0x3 CNT:** a write loads the counter and clears the prescaler count.
- **0x4 STATUS:** bit0 UIF, bits[1+:N_CH] CCxIF; write-1-to-clear.
- **0x8+i CCR[i].**
- Unmapped addresses read 0; writes to them are ignored.

Prescaler:
- When EN=1, `psc_cnt` counts 0..PSC and asserts `tick` when `psc_cnt==PSC`, then wraps to 0.
- PSC=0 gives a tick every cycle.
- When EN=0, `psc_cnt` holds and no tick occurs.

Counter, on each tick:
- **Up:**
  - If cnt==ARR: cnt←0 (update event).
  - Else cnt←cnt+1.
- **Down:**
  - If cnt==0: cnt←ARR (update event).
  - Else cnt←cnt−1.
- On an update event: UIF←1. If ONESHOT, EN←0; the counter keeps its post-event value.
- ARR=0: cnt stays 0 and an update event occurs on every tick.
- When cnt>ARR (ARR written below cnt):
  - Up mode counts on, wrapping modulo 2^CNT_W, until it reaches ARR.
  - Down mode counts down normally.

Compare:
- CCxIF[i]←1 on the edge where cnt is loaded with a value equal to CCR[i], whether by a tick or a CNT write.
- cmp_out is combinational from the registered cnt and CCR.
- CCR[i]=0 forces cmp_out[i]=0.
- CCR[i]>ARR forces cmp_out[i]=1 in steady periodic up-count.

Simultaneous events:
- Hardware flag set and W1C clear in the same cycle: set wins.
- CNT write and tick in the same cycle: the write wins, and no update event occurs from that tick.
- CTRL write clearing EN on a tick cycle: the tick still takes effect.
- One-shot EN clear and a software write setting EN in the same cycle: EN ends at 1.

Reset:
- All registers, psc_cnt, cnt, rdata, irq and cmp_out go to 0 immediately and asynchronously, including mid-count or mid-read.

## Timing
- Write: the register updates on the edge that samples `wr_en`.
- Read: `rdata` is valid the cycle after `rd_en` and holds until the next `rd_en`.
- The tick period is PSC+1 cycles; the counter period is (ARR+1)·(PSC+1) cycles.
- A flag is set on the same edge as the causing cnt change; `irq` rises one cycle after.
- After EN 0→1, the first tick is PSC+1 cycles later.

## Configuration
- `GP_TIMER_PRELOAD_EN` defined:
  - PSC and ARR writes land in shadow registers.
  - The active copies load from the shadows on the next update event, or immediately when EN=0.
  - Reads return the shadow values.
- Not defined:
  - PSC and ARR writes take effect on the next edge.
  - A PSC write also clears `psc_cnt`.

## Test plan
- **Basic up-count:** PSC=1, ARR=3, EN=1 → cnt follows 0,0,1,1,2,2,3,3,0; UIF sets on the wrap edge; irq is high 1 cycle later with UIE=1.
- **One-shot down:** ONESHOT=1, DIR=1, ARR=5, CNT=2, PSC=0 → cnt follows 2,1,0,5; EN reads 0 afterwards; no further change after 100 cycles.
- **PWM:** N_CH=2, ARR=9, CCR0=3, CCR1=0, PSC=0 → cmp_out[0] is high 3 of every 10 cycles; cmp_out[1] stays 0; CC0IF sets when cnt becomes 3.
- **Flag races:**
  - W1C of UIF on the same cycle as an update → UIF remains 1.
  - CNT write of 7 on a tick cycle → cnt=7 and no UIF.
- **Preload:** ARR=9 while counting, then write ARR=4 at cnt=6 → with the macro, wraps at 9 then 4; without it, cnt counts up through wrap-around to 4.
- **Asynchronous reset:** assert reset mid-count with irq high → cnt, irq, rdata and cmp_out all read 0 before the next clk edge.
